inst_fetch_buffer: RTL
======================

Name: inst_fetch_buffer

Overview:
- Instruction fetch stage directly downstream of the PC register.
- Takes each new instruction address and issues it to instruction memory over a valid/ready request channel.
- Pairs in-order memory responses with their PC in a DEPTH-entry buffer and presents {inst_pc, inst_code} to decode over valid/ready.
- Back-pressures the PC stage via addr_ready. Supports pipeline flush on branch/jump redirect, discarding responses still in flight.

Parameters:
- DEPTH, 4, buffer entries and maximum outstanding requests; power of two, 2..16.
- ADDR_W, 32, PC/address width.
- DATA_W, 32, instruction width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- inst_address  in  ADDR_W  address from PC stage
- addr_valid  in  1  inst_address is a new fetch address
- addr_ready  out  1  fetch accepted this cycle; PC stage must hold when low
- imem_req_valid  out  1  request to instruction memory
- imem_req_addr  out  ADDR_W  request address (= inst_address)
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  in-order response strobe, ≥1 cycle after request
- imem_resp_data  in  DATA_W  instruction word
- flush  in  1  redirect: drop all buffered and in-flight fetches
- inst_valid  out  1  head entry holds a returned instruction
- inst_code  out  DATA_W  head instruction; 32'h00000013 (NOP) when inst_valid=0
- inst_pc  out  ADDR_W  head PC; 0 when inst_valid=0
- inst_ready  in  1  decode consumes head

Behaviour:
- State:
  - entry[DEPTH] = {pc, data, filled}
  - wr_ptr (alloc), fill_ptr (response), rd_ptr (pop), each log2(DEPTH)+1 bits with wrap bit
  - inflight counter 0..DEPTH (issued requests not yet responded)
  - discard counter 0..DEPTH
- Reset (async, any time, including mid-transfer):
  - All pointers, inflight and discard = 0; all filled bits = 0.
  - Outputs: inst_valid=0, inst_code=32'h00000013, inst_pc=0, imem_req_valid=0, addr_ready=0.
- Request issue:
  - Combinational: can_alloc = !flush && (wr_ptr - rd_ptr) < DEPTH, using registered pointers. A pop in the same cycle does not free space.
  - imem_req_valid = addr_valid && can_alloc.
  - imem_req_addr = inst_address.
  - addr_ready = can_alloc && imem_req_ready.
- Issue handshake (imem_req_valid && imem_req_ready):
  - entry[wr_ptr].pc <= inst_address, filled <= 0
  - wr_ptr++, inflight++
- Response (imem_resp_valid):
  - inflight--, always.
  - If flush this cycle or discard>0: data dropped; discard-- if discard>0.
  - Otherwise: entry[fill_ptr].data <= imem_resp_data, filled <= 1, fill_ptr++.
  - Response with inflight==0 is a protocol violation: ignored, no counter changes.
- Output:
  - inst_valid = (rd_ptr != wr_ptr) && entry[rd_ptr].filled.
  - inst_code/inst_pc driven combinationally from entry[rd_ptr].
  - Latency: response at cycle N, inst_valid high at cycle N+1.
  - Pop on inst_valid && inst_ready && !flush: filled <= 0, rd_ptr++.
- Flush cycle:
  - No request issued, no pop.
  - rd_ptr, fill_ptr <= wr_ptr; all filled bits cleared.
  - discard <= inflight after this cycle's response decrement.
  - Next cycle: inst_valid=0; new fetches may issue immediately, and responses to them are accepted only after discard reaches 0.
- Order: strict in-order; no reordering, no duplicate PCs.
- Width: pointer arithmetic is modulo 2^(log2(DEPTH)+1); full when pointers differ only in the wrap bit.

Test Plan:
1. Reset mid-run: 3 requests in flight, assert reset → next cycle all outputs at reset values, inst_code=32'h00000013; later responses ignored while reset is held.
2. Streaming, 1-cycle memory, inst_ready=1, addresses 0,4,8,12 → inst_pc 0,4,8,12 with matching data 0xAAAA0000+pc, each one cycle after its response; addr_ready stays 1.
3. Back-pressure, DEPTH=4, inst_ready=0, memory always responds → after 4 accepts addr_ready=0 and imem_req_valid=0. Raise inst_ready for one cycle: pop pc 0; addr_ready=1 the following cycle, not the same one.
4. Flush with 2 in flight: issue 0x100 and 0x104, flush before responses, then issue 0x200 → the two late responses are dropped, discard goes 2→0, and the first inst_valid shows pc=0x200.
5. Flush coincident with a response: inflight=1, response and flush in the same cycle → data dropped, discard=0, inst_valid=0 next cycle.
6. Wrap-around: 10 fetches with a random stall pattern on inst_ready and imem_req_ready → PCs 0..36 emerge in order, none lost or duplicated, pointers wrap correctly.

Source files
------------

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: issues PC-stage addresses to instruction memory, pairs in-order
// responses with their PCs in a DEPTH-entry ring and hands {pc, instruction} to decode.
module inst_fetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] inst_address,
  input  logic              addr_valid,
  output logic              addr_ready,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  input  logic              flush,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_code,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0]     DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0]     PTR_ONE = PW'(1);
  localparam logic [DATA_W-1:0] NOP     = DATA_W'(32'h0000_0013);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  filled;

  logic [PW-1:0] wr_ptr, fill_ptr, rd_ptr;
  logic [PW-1:0] inflight, discard;
  logic [PW-1:0] occupancy;
  logic [IW-1:0] wr_idx, fill_idx, rd_idx;

  logic can_alloc, issue, resp_ok, resp_drop, resp_fill, pop;

  assign wr_idx    = wr_ptr[IW-1:0];
  assign fill_idx  = fill_ptr[IW-1:0];
  assign rd_idx    = rd_ptr[IW-1:0];
  assign occupancy = wr_ptr - rd_ptr;

  // Space is judged on registered pointers only, so a same-cycle pop never frees a slot.
  assign can_alloc = !flush && (occupancy < DEPTH_P);
  assign issue     = addr_valid && can_alloc && imem_req_ready;

  // Responses with nothing outstanding are protocol violations and are ignored outright.
  assign resp_ok   = imem_resp_valid && (inflight != '0);
  assign resp_drop = resp_ok && (flush || (discard != '0));
  assign resp_fill = resp_ok && !resp_drop;

  assign inst_valid = (rd_ptr != wr_ptr) && filled[rd_idx];
  assign pop        = inst_valid && inst_ready && !flush;

  // Handshake outputs are forced idle while reset is asserted.
  assign imem_req_valid = addr_valid && can_alloc && !reset;
  assign addr_ready     = can_alloc && imem_req_ready && !reset;
  assign imem_req_addr  = inst_address;

  assign inst_code = inst_valid ? data_mem[rd_idx] : NOP;
  assign inst_pc   = inst_valid ? pc_mem[rd_idx]   : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
      discard  <= '0;
      filled   <= '0;
    end else begin
      inflight <= inflight + PW'(issue) - PW'(resp_ok);
      if (flush) begin
        // Everything buffered is dropped; responses still owed are swallowed later.
        rd_ptr   <= wr_ptr;
        fill_ptr <= wr_ptr;
        filled   <= '0;
        discard  <= inflight - PW'(resp_ok);
      end else begin
        if (issue) begin
          wr_ptr         <= wr_ptr + PTR_ONE;
          filled[wr_idx] <= 1'b0;
        end
        if (resp_fill) begin
          fill_ptr         <= fill_ptr + PTR_ONE;
          filled[fill_idx] <= 1'b1;
        end
        if (pop) begin
          rd_ptr         <= rd_ptr + PTR_ONE;
          filled[rd_idx] <= 1'b0;
        end
        if (resp_drop) begin
          discard <= discard - PTR_ONE;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (issue) begin
      pc_mem[wr_idx] <= inst_address;
    end
    if (resp_fill) begin
      data_mem[fill_idx] <= imem_resp_data;
    end
  end

endmodule
